// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and types for the register-file port master.
//   DATA_W / ADDR_W / NUM_REGS / TAG_W - register file geometry and tag width
//   rd_rsp_t  - one buffered read response {tag, data0, data1}
//   rf_state_e - front-end state: CLEAR (zeroing registers) or RUN
package rf_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int TAG_W    = 4;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
  } rd_rsp_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;
endpackage

// File: rtl/rf_rsp_fifo.sv
// rf_rsp_fifo: synchronous FIFO of rd_rsp_t, DEPTH entries (power of two, >=2).
//   clk, reset      - clock, async active-high reset (empties the FIFO)
//   push, push_data - enqueue; ignored when full unless a pop happens too
//   pop, pop_data   - dequeue head; pop_data is the current head
//   full, empty, count - occupancy
module rf_rsp_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  rd_rsp_t          push_data,
  input  logic             pop,
  output rd_rsp_t          pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  rd_rsp_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
    else if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/rf_port_master.sv
// rf_port_master: requester-side front end for a 16x32 2R1W register file.
//   Clears every register after reset / clear_req (clear_busy high meanwhile),
//   passes write requests straight to the write port, and captures the
//   combinational read data of accepted reads into a tagged response FIFO.
// Ports:
//   clk, reset (async, active-high), clear_req, clear_busy
//   rd_req_* (valid/ready, mask, addr0, addr1, tag) -> rd_rsp_* (valid/ready,
//   data0, data1, tag); wr_req_* (valid/ready, addr, data)
//   rf_* - control/data ports of the register file
// Build option: define RF_RAW_FWD_EN to forward same-cycle write data to a
// matching enabled read port; otherwise the old register value is returned.
module rf_port_master
  import rf_pkg::*;
#(
  parameter int RSP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clear_busy,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [1:0]        rd_req_mask,
  input  logic [ADDR_W-1:0] rd_req_addr0,
  input  logic [ADDR_W-1:0] rd_req_addr1,
  input  logic [TAG_W-1:0]  rd_req_tag,
  output logic              rd_rsp_valid,
  input  logic              rd_rsp_ready,
  output logic [DATA_W-1:0] rd_rsp_data0,
  output logic [DATA_W-1:0] rd_rsp_data1,
  output logic [TAG_W-1:0]  rd_rsp_tag,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic [1:0]        rf_read_en,
  output logic [ADDR_W-1:0] rf_raddr_0,
  output logic [ADDR_W-1:0] rf_raddr_1,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata_0,
  input  logic [DATA_W-1:0] rf_rdata_1
);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(NUM_REGS - 1);
  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clear_busy_q, clear_busy_d;
  logic              run, rd_fire, wr_fire, pop, full, empty;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] d0, d1;
  rd_rsp_t           push_data, pop_data;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        if (clear_req) begin
          clr_cnt_d = '0;
        end else if (clr_cnt_q == CLR_LAST) begin
          state_d   = RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
    endcase
    clear_busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= CLEAR;
      clr_cnt_q    <= '0;
      clear_busy_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      clear_busy_q <= clear_busy_d;
    end
  end

  assign clear_busy = clear_busy_q;

  // Reset gates every handshake and register-file strobe directly, since the
  // CLEAR state itself would otherwise drive write enables during reset.
  assign run          = (state_q == RUN) & ~reset;
  assign wr_req_ready = run;
  assign rd_req_ready = run & (~full | rd_rsp_ready);
  assign wr_fire      = wr_req_valid & wr_req_ready;
  assign rd_fire      = rd_req_valid & rd_req_ready;

  assign rf_write_en = ~reset & ((state_q == CLEAR) | wr_fire);
  assign rf_waddr    = (state_q == CLEAR) ? clr_cnt_q : wr_req_addr;
  assign rf_wdata    = (state_q == CLEAR) ? '0 : wr_req_data;

  assign rf_read_en = rd_fire ? rd_req_mask : 2'b00;
  assign rf_raddr_0 = rd_req_addr0;
  assign rf_raddr_1 = rd_req_addr1;

`ifdef RF_RAW_FWD_EN
  // The register file only updates at the edge, so a same-cycle write to a
  // port's address is substituted here to give read-after-write semantics.
  assign d0 = !rd_req_mask[0] ? '0 :
              (wr_fire && wr_req_addr == rd_req_addr0) ? wr_req_data : rf_rdata_0;
  assign d1 = !rd_req_mask[1] ? '0 :
              (wr_fire && wr_req_addr == rd_req_addr1) ? wr_req_data : rf_rdata_1;
`else
  assign d0 = rd_req_mask[0] ? rf_rdata_0 : '0;
  assign d1 = rd_req_mask[1] ? rf_rdata_1 : '0;
`endif

  assign push_data = '{tag: rd_req_tag, data0: d0, data1: d1};
  assign pop       = rd_rsp_ready & ~empty;

  rf_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_fire),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign rd_rsp_valid = ~empty;
  assign rd_rsp_tag   = pop_data.tag;
  assign rd_rsp_data0 = pop_data.data0;
  assign rd_rsp_data1 = pop_data.data1;

  logic unused_ok;
  assign unused_ok = ^count;
endmodule

// File: tb/tb_rf_port_master.sv
// tb_rf_port_master: scenario bench for rf_port_master with a behavioural
// 16x32 register file attached. Expected read responses are pushed to a
// scoreboard queue when a read is accepted and compared when popped.
module tb_rf_port_master;
  logic        clk, reset, clear_req, clear_busy;
  logic        rd_req_valid, rd_req_ready, rd_rsp_valid, rd_rsp_ready;
  logic [1:0]  rd_req_mask, rf_read_en;
  logic [3:0]  rd_req_addr0, rd_req_addr1, rd_req_tag, rd_rsp_tag;
  logic [31:0] rd_rsp_data0, rd_rsp_data1;
  logic        wr_req_valid, wr_req_ready, rf_write_en;
  logic [3:0]  wr_req_addr, rf_raddr_0, rf_raddr_1, rf_waddr;
  logic [31:0] wr_req_data, rf_wdata, rf_rdata_0, rf_rdata_1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] d0;
    logic [31:0] d1;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] exp_regs [16];

  rf_port_master #(.RSP_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .clear_busy(clear_busy),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_mask(rd_req_mask), .rd_req_addr0(rd_req_addr0),
    .rd_req_addr1(rd_req_addr1), .rd_req_tag(rd_req_tag),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
    .rd_rsp_data0(rd_rsp_data0), .rd_rsp_data1(rd_rsp_data1),
    .rd_rsp_tag(rd_rsp_tag),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .rf_read_en(rf_read_en), .rf_raddr_0(rf_raddr_0), .rf_raddr_1(rf_raddr_1),
    .rf_write_en(rf_write_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_rdata_0(rf_rdata_0), .rf_rdata_1(rf_rdata_1)
  );

  // Behavioural register file, powered up with garbage so the clear matters.
  logic [31:0] rf_mem [16] = '{default: 32'hBAD0BAD0};
  always @(posedge clk) if (rf_write_en) rf_mem[rf_waddr] <= rf_wdata;
  assign rf_rdata_0 = rf_mem[rf_raddr_0];
  assign rf_rdata_1 = rf_mem[rf_raddr_1];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Scoreboard: pop/compare on response handshake, push on request handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (rd_rsp_valid && rd_rsp_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected tag=%0d got a response, required none", rd_rsp_tag);
        end else begin
          e = sb.pop_front();
          if ({rd_rsp_tag, rd_rsp_data0, rd_rsp_data1} !== {e.tag, e.d0, e.d1}) begin
            n_fail++;
            $display("FAIL rsp_data got tag=%0d d0=%h d1=%h required tag=%0d d0=%h d1=%h",
                     rd_rsp_tag, rd_rsp_data0, rd_rsp_data1, e.tag, e.d0, e.d1);
          end
        end
      end
      if (rd_req_valid && rd_req_ready) begin
        e.tag = rd_req_tag;
        e.d0  = rd_req_mask[0] ? exp_regs[rd_req_addr0] : 32'h0;
        e.d1  = rd_req_mask[1] ? exp_regs[rd_req_addr1] : 32'h0;
`ifdef RF_RAW_FWD_EN
        if (wr_req_valid && wr_req_ready) begin
          if (rd_req_mask[0] && wr_req_addr == rd_req_addr0) e.d0 = wr_req_data;
          if (rd_req_mask[1] && wr_req_addr == rd_req_addr1) e.d1 = wr_req_data;
        end
`endif
        sb.push_back(e);
      end
      if (wr_req_valid && wr_req_ready) exp_regs[wr_req_addr] = wr_req_data;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    wr_req_valid = 1'b1; wr_req_addr = a; wr_req_data = d;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (wr_req_ready) break;
      if (n == 59) begin n_tests++; n_fail++; $display("FAIL wr_timeout got no ready, required ready"); end
    end
    cyc();
    wr_req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] m, input logic [3:0] a0, input logic [3:0] a1,
                         input logic [3:0] t);
    rd_req_valid = 1'b1; rd_req_mask = m; rd_req_addr0 = a0; rd_req_addr1 = a1; rd_req_tag = t;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (rd_req_ready) break;
      if (n == 59) begin n_tests++; n_fail++; $display("FAIL rd_timeout got no ready, required ready"); end
    end
    cyc();
    rd_req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && sb.size() != 0; n++) cyc();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout got %0d pending, required 0", sb.size());
    end
    cyc();
  endtask

  task automatic check_clear_sweep(input string name);
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (clear_busy !== 1'b1 || rf_write_en !== 1'b1 || rf_waddr !== 4'(i) ||
          rf_wdata !== 32'h0 || wr_req_ready !== 1'b0 || rd_req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_cycle%0d got busy=%b we=%b waddr=%0d wdata=%h wr_rdy=%b rd_rdy=%b required 1 1 %0d 0 0 0",
                 name, i, clear_busy, rf_write_en, rf_waddr, rf_wdata, wr_req_ready, rd_req_ready, i);
      end
      @(negedge clk);
    end
    n_tests++;
    if (clear_busy !== 1'b0 || wr_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done got busy=%b wr_rdy=%b required 0 1", name, clear_busy, wr_req_ready);
    end
    for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0; clear_req = 1'b0; rd_req_valid = 1'b0; rd_rsp_ready = 1'b1;
    rd_req_mask = 2'b00; rd_req_addr0 = '0; rd_req_addr1 = '0; rd_req_tag = '0;
    wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0;
    #1 reset = 1'b1;
    #2;
    n_tests++;
    if (clear_busy !== 1'b1 || rd_rsp_valid !== 1'b0 || rf_write_en !== 1'b0 ||
        rf_read_en !== 2'b00 || rd_req_ready !== 1'b0 || wr_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got busy=%b rsp_v=%b we=%b re=%b rd_rdy=%b wr_rdy=%b required 1 0 0 00 0 0",
               clear_busy, rd_rsp_valid, rf_write_en, rf_read_en, rd_req_ready, wr_req_ready);
    end
    #7 reset = 1'b0;  // t=10, a falling clock edge
    #1;
    check_clear_sweep("post_reset_clear");
    cyc();
  endtask

  task automatic test_write_read();
    do_write(4'd5, 32'hDEADBEEF);
    rd_req_valid = 1'b1; rd_req_mask = 2'b11; rd_req_addr0 = 4'd5; rd_req_addr1 = 4'd5; rd_req_tag = 4'd3;
    @(negedge clk);
    n_tests++;
    if (rd_req_ready !== 1'b1 || rf_read_en !== 2'b11) begin
      n_fail++;
      $display("FAIL rd_accept got rdy=%b re=%b required 1 11", rd_req_ready, rf_read_en);
    end
    cyc();
    rd_req_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rd_rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rsp_latency got valid=%b required 1", rd_rsp_valid);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    rd_rsp_ready = 1'b0;
    do_read(2'b01, 4'd5, 4'd0, 4'd1);
    do_read(2'b10, 4'd0, 4'd5, 4'd2);
    rd_req_valid = 1'b1; rd_req_mask = 2'b11; rd_req_addr0 = 4'd1; rd_req_addr1 = 4'd5; rd_req_tag = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (rd_req_ready !== 1'b0 || rd_rsp_valid !== 1'b1 || rd_rsp_tag !== 4'd1) begin
        n_fail++;
        $display("FAIL full_stall got rdy=%b rsp_v=%b tag=%0d required 0 1 1",
                 rd_req_ready, rd_rsp_valid, rd_rsp_tag);
      end
      cyc();
    end
    rd_rsp_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (rd_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_with_pop got rdy=%b required 1", rd_req_ready);
    end
    cyc();
    rd_req_valid = 1'b0;
    drain();
  endtask

  task automatic test_raw_hazard();
    do_write(4'd7, 32'hA5A5A5A5);
    wr_req_valid = 1'b1; wr_req_addr = 4'd7; wr_req_data = 32'h12345678;
    rd_req_valid = 1'b1; rd_req_mask = 2'b01; rd_req_addr0 = 4'd7; rd_req_addr1 = 4'd2; rd_req_tag = 4'd5;
    @(negedge clk);
    n_tests++;
    if (rd_req_ready !== 1'b1 || wr_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_accept got rd_rdy=%b wr_rdy=%b required 1 1", rd_req_ready, wr_req_ready);
    end
    cyc();
    wr_req_valid = 1'b0; rd_req_valid = 1'b0;
    do_read(2'b01, 4'd7, 4'd0, 4'd6);
    drain();
  endtask

  task automatic test_mask();
    do_write(4'd9, 32'h0909CAFE);
    do_read(2'b10, 4'd5, 4'd9, 4'd8);
    do_read(2'b00, 4'd5, 4'd9, 4'd9);
    drain();
  endtask

  task automatic test_clear_reset();
    do_write(4'd3, 32'h1);
    do_read(2'b01, 4'd3, 4'd0, 4'd4);
    drain();
    clear_req = 1'b1;
    wr_req_valid = 1'b1; wr_req_addr = 4'd4; wr_req_data = 32'h44;
    @(negedge clk);
    n_tests++;
    if (rf_write_en !== 1'b1 || rf_waddr !== 4'd4 || rf_wdata !== 32'h44) begin
      n_fail++;
      $display("FAIL clear_req_write got we=%b waddr=%0d wdata=%h required 1 4 00000044",
               rf_write_en, rf_waddr, rf_wdata);
    end
    cyc();
    clear_req = 1'b0; wr_req_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (clear_busy !== 1'b1 || rf_waddr !== 4'd0) begin
      n_fail++;
      $display("FAIL clear_start got busy=%b waddr=%0d required 1 0", clear_busy, rf_waddr);
    end
    for (int i = 0; i < 4; i++) cyc();
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (clear_busy !== 1'b1 || rf_write_en !== 1'b0 || rd_req_ready !== 1'b0 || rd_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midclear_reset got busy=%b we=%b rd_rdy=%b rsp_v=%b required 1 0 0 0",
               clear_busy, rf_write_en, rd_req_ready, rd_rsp_valid);
    end
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check_clear_sweep("restart_clear");
    cyc();
    do_read(2'b11, 4'd3, 4'd7, 4'd10);
    drain();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_raw_hazard();
    test_mask();
    test_clear_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
